bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen_pkg.sv | 22 ++
 rtl/bounce_gen_if.sv | 12 +
 rtl/bounce_gen_lfsr16.sv | 28 ++
 rtl/bounce_gen.sv | 131 +++++++++++++
 tb/tb_bounce_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the mechanical-switch bounce emulator:
// FSM state encoding, LFSR seed/tap mask and the LFSR step function.
package bounce_gen_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BOUNCE_DN = 3'd1,
    HOLD_DN   = 3'd2,
    BOUNCE_UP = 3'd3,
    HOLD_UP   = 3'd4
  } state_e;

  // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_gen_if.sv
// Press request / emulated switch handshake between a requester and bounce_gen.
interface bounce_gen_if;

  logic i_Press;
  logic o_Switch;
  logic o_Busy;
  logic o_Done;

  modport master (output i_Press, input o_Switch, input o_Busy, input o_Done);
  modport slave  (input i_Press, output o_Switch, output o_Busy, output o_Done);

endinterface

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit free-running Galois LFSR; reloads the seed whenever reset is high.
module lfsr16 (
  input  logic        i_Clk,
  input  logic        i_Reset,
  output logic [15:0] o_Lfsr
);
  import bounce_gen_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR state.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // State register; advances every non-reset cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_Lfsr = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates one press-and-release of a bouncy mechanical switch per accepted
// i_Press: a burst of randomly spaced toggles settling at 1, a stable hold,
// a mirrored burst settling at 0, another hold, then a one-cycle o_Done.
module bounce_gen #(
  parameter int unsigned BOUNCE_COUNT = 3,
  parameter int unsigned MIN_GAP      = 4,
  parameter int unsigned GAP_BITS     = 4,
  parameter int unsigned HOLD_CYCLES  = 1000
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  bounce_gen_if.slave   bus
);
  import bounce_gen_pkg::*;

  localparam int unsigned GAP_MAX = MIN_GAP + (1 << GAP_BITS) - 1;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TOGGLES = 2 * BOUNCE_COUNT + 1;
  localparam int unsigned TGL_W   = $clog2(TOGGLES + 1);

  logic [15:0]       lfsr;
  logic [GAP_W-1:0]  gap_load;
  logic              unused_lfsr_bits;

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TGL_W-1:0]  tgl_q, tgl_d;
  logic              sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  lfsr16 u_lfsr (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .o_Lfsr  (lfsr)
  );

  // Only the low bits shape the gap; the rest just carry the sequence.
  assign unused_lfsr_bits = ^lfsr;
  assign gap_load = GAP_W'(MIN_GAP) + GAP_W'(lfsr[GAP_BITS-1:0]);

  // Next-state logic. Every toggle reloads the gap counter; a bounce phase
  // spends one extra cycle after its last toggle before entering the hold.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    tgl_d   = tgl_q;
    sw_d    = sw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Press) begin
          state_d = BOUNCE_DN;
          sw_d    = 1'b1;
          tgl_d   = TGL_W'(1);
          gap_d   = gap_load;
        end
      end
      BOUNCE_DN, BOUNCE_UP: begin
        if (tgl_q == TGL_W'(TOGGLES)) begin
          state_d = (state_q == BOUNCE_DN) ? HOLD_DN : HOLD_UP;
          hold_d  = HOLD_W'(HOLD_CYCLES);
          gap_d   = '0;
          tgl_d   = '0;
        end else if (gap_q == GAP_W'(1)) begin
          sw_d  = ~sw_q;
          tgl_d = tgl_q + TGL_W'(1);
          gap_d = gap_load;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      HOLD_DN: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = BOUNCE_UP;
          sw_d    = 1'b0;
          tgl_d   = TGL_W'(1);
          gap_d   = gap_load;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      HOLD_UP: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sw_d    = 1'b0;
        gap_d   = '0;
        hold_d  = '0;
        tgl_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD_UP) && (hold_d == HOLD_W'(1));
  end

  // FSM and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      hold_q  <= '0;
      tgl_q   <= '0;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      tgl_q   <= tgl_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_Switch = sw_q;
  assign bus.o_Busy   = busy_q;
  assign bus.o_Done   = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: two instances (with and without bounces) share
// clock, reset and press; an event-time model predicts every output cycle.
module tb_bounce_gen;

  localparam int B0 = 2;
  localparam int B1 = 0;
  localparam int MG = 2;
  localparam int GM = 3;   // 2^GAP_BITS - 1
  localparam int HC = 10;
  localparam int LFN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic press = 1'b0;

  always #5 clk = ~clk;

  bounce_gen_if bus0 ();
  bounce_gen_if bus1 ();
  assign bus0.i_Press = press;
  assign bus1.i_Press = press;

  bounce_gen #(.BOUNCE_COUNT(B0), .MIN_GAP(MG), .GAP_BITS(2), .HOLD_CYCLES(HC)) u_dut0 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus0)
  );
  bounce_gen #(.BOUNCE_COUNT(B1), .MIN_GAP(MG), .GAP_BITS(2), .HOLD_CYCLES(HC)) u_dut1 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus1)
  );

  // Reference model: toggle times are absolute cycle numbers since reset.
  logic [15:0] lf [LFN];
  int n = 0;
  int tt [2][12];
  int ntt [2];
  int t_start [2];
  int t_done [2];
  int done_exp;
  int done_obs;
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", tag, n, got, exp);
    end
  endtask

  // LFSR from the polynomial: term x^e sets tap bit e-1.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    logic [15:0] taps;
    taps = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
    r = s >> 1;
    if (s[0]) r = r ^ taps;
    return r;
  endfunction

  function automatic int gap_at(input int t);
    return MG + int'(lf[(t - 1) % LFN] & 16'(GM));
  endfunction

  // Press sampled during cycle p: first toggle at p+1, bounces spaced by
  // random gaps, one settle cycle plus HC hold cycles between phases.
  function automatic void schedule(input int id, input int p, input int b);
    int t;
    t = p + 1;
    ntt[id] = 0;
    tt[id][ntt[id]++] = t;
    for (int i = 0; i < 2 * b; i++) begin
      t = t + gap_at(t);
      tt[id][ntt[id]++] = t;
    end
    t = t + 1 + HC;
    tt[id][ntt[id]++] = t;
    for (int i = 0; i < 2 * b; i++) begin
      t = t + gap_at(t);
      tt[id][ntt[id]++] = t;
    end
    t_start[id] = p + 1;
    t_done[id]  = t + HC;
  endfunction

  function automatic int busy_at(input int id, input int nn);
    return int'((nn >= t_start[id]) && (nn <= t_done[id]));
  endfunction

  function automatic int sw_at(input int id, input int nn);
    int c;
    c = 0;
    for (int k = 0; k < ntt[id]; k++) if (tt[id][k] <= nn) c++;
    return c & 1;
  endfunction

  // Apply inputs for one cycle, advance the model over the edge, compare.
  task automatic tick(input logic r, input logic p);
    int pb0, pb1;
    rst = r;
    press = p;
    pb0 = busy_at(0, n);
    pb1 = busy_at(1, n);
    @(posedge clk);
    #1;
    if (r) begin
      n = 0;
      for (int id = 0; id < 2; id++) begin
        ntt[id] = 0;
        t_start[id] = 0;
        t_done[id] = -1;
      end
    end else begin
      n++;
      if (p && pb0 == 0) schedule(0, n - 1, B0);
      if (p && pb1 == 0) schedule(1, n - 1, B1);
    end
    chk("sw0",   int'(bus0.o_Switch), sw_at(0, n));
    chk("busy0", int'(bus0.o_Busy),   busy_at(0, n));
    chk("done0", int'(bus0.o_Done),   int'(n == t_done[0]));
    chk("sw1",   int'(bus1.o_Switch), sw_at(1, n));
    chk("busy1", int'(bus1.o_Busy),   busy_at(1, n));
    chk("done1", int'(bus1.o_Done),   int'(n == t_done[1]));
    if (n == t_done[0]) done_exp++;
    if (bus0.o_Done) done_obs++;
  endtask

  initial begin
    int idle0;
    int idle;
    logic r, pr;
    lf[0] = 16'hACE1;
    for (int k = 0; k < LFN - 1; k++) lf[k + 1] = ref_step(lf[k]);
    for (int id = 0; id < 2; id++) begin
      ntt[id] = 0;
      t_start[id] = 0;
      t_done[id] = -1;
    end
    idle0 = $urandom_range(0, 12);

    repeat (3) tick(1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      done_exp = 0;
      done_obs = 0;
      idle = (s == 0 || s == 5) ? idle0 : $urandom_range(0, 12);
      if (s == 2) tick(1'b1, 1'b1);   // press under reset must be ignored
      repeat (idle) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      for (int c = 0; c < 400; c++) begin
        pr = 1'b0;
        r  = 1'b0;
        if (busy_at(0, n) != 0 && busy_at(1, n) != 0 && $urandom_range(0, 7) == 0) pr = 1'b1;
        if (s == 1 && n == tt[0][2 * B0] + 3) pr = 1'b1;   // mid HOLD_DN
        if (s == 3 && n == t_done[0]) pr = 1'b1;           // on the done cycle
        if (s == 4 && n == tt[0][2 * B0 + 2]) r = 1'b1;     // inside BOUNCE_UP
        tick(r, pr);
        if (busy_at(0, n) == 0 && busy_at(1, n) == 0) break;
      end
      chk("settled", int'(bus0.o_Busy | bus1.o_Busy), 0);
      chk("done_cnt0", done_obs, done_exp);
      if (s == 3) tick(1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecs, errs);
    $fatal(1);
  end

endmodule
